// File: rtl/lookup_remap_table_if.sv
// Descriptor-in, descriptor-out and remap RAM read bus of the
// transmit-side TSN tag to DMAC lookup.
interface lookup_remap_table_if #(
    parameter int ADDR_W = 5
);
    logic [47:0]       iv_tsntag;
    logic [8:0]        iv_bufid;
    logic              i_descriptor_wr;
    logic              o_lookup_idle;
    logic              o_remap_ram_rd;
    logic [ADDR_W-1:0] ov_remap_ram_raddr;
    logic [62:0]       iv_remap_ram_rdata;
    logic [47:0]       ov_dmac;
    logic [2:0]        ov_pkt_type;
    logic [8:0]        ov_bufid;
    logic              o_remap_hit;
    logic              o_descriptor_wr;
    logic [15:0]       ov_drop_cnt;

    modport slave (
        input  iv_tsntag, iv_bufid, i_descriptor_wr, iv_remap_ram_rdata,
        output o_lookup_idle, o_remap_ram_rd, ov_remap_ram_raddr,
        output ov_dmac, ov_pkt_type, ov_bufid, o_remap_hit,
        output o_descriptor_wr, ov_drop_cnt
    );

    modport master (
        output iv_tsntag, iv_bufid, i_descriptor_wr, iv_remap_ram_rdata,
        input  o_lookup_idle, o_remap_ram_rd, ov_remap_ram_raddr,
        input  ov_dmac, ov_pkt_type, ov_bufid, o_remap_hit,
        input  o_descriptor_wr, ov_drop_cnt
    );
endinterface

// File: rtl/lookup_remap_table.sv
// Restores the original DMAC of a transmit descriptor by a sequential
// flow-ID search of the remap RAM; BE descriptors bypass the search.
module lookup_remap_table #(
    parameter int TABLE_DEPTH = 32,
    parameter int ADDR_W      = 5
) (
    input logic                 i_clk,
    input logic                 i_rst_n,
    lookup_remap_table_if.slave bus
);
    localparam logic [0:0] IDLE_S   = 1'b0;
    localparam logic [0:0] SEARCH_S = 1'b1;
    localparam logic [2:0] BE_TYPE  = 3'd6;
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(TABLE_DEPTH - 1);

    logic [0:0]        state_q, state_d;
    logic [47:0]       tag_q, tag_d;
    logic [8:0]        bufid_q, bufid_d;
    logic              rd_q, rd_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic              v1_q, v1_d;
    logic              v2_q, v2_d;
    logic [ADDR_W-1:0] cmp_q, cmp_d;
    logic              wr_q, wr_d;
    logic [47:0]       dmac_q, dmac_d;
    logic [2:0]        type_q, type_d;
    logic [8:0]        obuf_q, obuf_d;
    logic              hit_q, hit_d;
    logic [15:0]       drop_q, drop_d;

    logic ent_vld;
    logic ent_match;

    assign ent_vld   = bus.iv_remap_ram_rdata[62];
    assign ent_match = bus.iv_remap_ram_rdata[61:48] == tag_q[44:31];

    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        bufid_d = bufid_q;
        rd_d    = rd_q;
        raddr_d = raddr_q;
        v1_d    = rd_q;
        v2_d    = v1_q;
        cmp_d   = cmp_q;
        drop_d  = drop_q;
        wr_d    = 1'b0;
        dmac_d  = '0;
        type_d  = '0;
        obuf_d  = '0;
        hit_d   = 1'b0;
        unique case (state_q)
            IDLE_S: begin
                if (bus.i_descriptor_wr) begin
                    if (bus.iv_tsntag[47:45] == BE_TYPE) begin
                        wr_d   = 1'b1;
                        dmac_d = bus.iv_tsntag;
                        type_d = BE_TYPE;
                        obuf_d = bus.iv_bufid;
                    end else begin
                        tag_d   = bus.iv_tsntag;
                        bufid_d = bus.iv_bufid;
                        rd_d    = 1'b1;
                        raddr_d = '0;
                        cmp_d   = '0;
                        state_d = SEARCH_S;
                    end
                end
            end
            SEARCH_S: begin
                if (bus.i_descriptor_wr && drop_q != 16'hFFFF) begin
                    drop_d = drop_q + 16'd1;
                end
                if (rd_q) begin
                    if (raddr_q == LAST_A) rd_d = 1'b0;
                    else raddr_d = raddr_q + ADDR_W'(1);
                end
                // v2_q marks the cycle the data for address cmp_q is on rdata
                if (v2_q) begin
                    cmp_d = cmp_q + ADDR_W'(1);
                    if (!ent_vld || ent_match || cmp_q == LAST_A) begin
                        wr_d    = 1'b1;
                        hit_d   = ent_vld && ent_match;
                        dmac_d  = hit_d ? bus.iv_remap_ram_rdata[47:0] : tag_q;
                        type_d  = tag_q[47:45];
                        obuf_d  = bufid_q;
                        rd_d    = 1'b0;
                        raddr_d = '0;
                        v1_d    = 1'b0;
                        v2_d    = 1'b0;
                        state_d = IDLE_S;
                    end
                end
            end
            default: state_d = IDLE_S;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE_S;
            tag_q   <= '0;
            bufid_q <= '0;
            rd_q    <= 1'b0;
            raddr_q <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            cmp_q   <= '0;
            wr_q    <= 1'b0;
            dmac_q  <= '0;
            type_q  <= '0;
            obuf_q  <= '0;
            hit_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            bufid_q <= bufid_d;
            rd_q    <= rd_d;
            raddr_q <= raddr_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            cmp_q   <= cmp_d;
            wr_q    <= wr_d;
            dmac_q  <= dmac_d;
            type_q  <= type_d;
            obuf_q  <= obuf_d;
            hit_q   <= hit_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.o_lookup_idle      = state_q == IDLE_S;
    assign bus.o_remap_ram_rd     = rd_q;
    assign bus.ov_remap_ram_raddr = raddr_q;
    assign bus.ov_dmac            = dmac_q;
    assign bus.ov_pkt_type        = type_q;
    assign bus.ov_bufid           = obuf_q;
    assign bus.o_remap_hit        = hit_q;
    assign bus.o_descriptor_wr    = wr_q;
    assign bus.ov_drop_cnt        = drop_q;
endmodule

// File: tb/tb_lookup_remap_table.sv
// Directed bench for lookup_remap_table with a table-scan reference
// model and a 2-cycle-latency remap RAM.
module tb_lookup_remap_table;
    localparam int DEPTH = 32;

    typedef struct {
        int          cyc;
        logic [47:0] dmac;
        logic [2:0]  ptype;
        logic [8:0]  bufid;
        logic        hit;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    lookup_remap_table_if #(.ADDR_W(5)) bus ();

    lookup_remap_table #(.TABLE_DEPTH(DEPTH), .ADDR_W(5)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [62:0] mem [DEPTH];
    logic [62:0] d1 = '0;
    logic [62:0] d2 = '0;
    always @(posedge clk) begin
        d1 <= bus.o_remap_ram_rd ? mem[bus.ov_remap_ram_raddr] : 63'd0;
        d2 <= d1;
    end
    assign bus.iv_remap_ram_rdata = d2;

    exp_t q[$];
    int   srch_t = -1;
    int   srch_o = 0;
    int   m_drop = 0;
    int   drop_cyc = -1;
    int   nwr = 0;
    int   last_wr_cyc = -1;
    logic [47:0] last_dmac;
    logic [8:0]  last_bufid;
    logic        last_hit;
    int   t_strobe;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endfunction

    function automatic void model_reset();
        q.delete();
        srch_t = -1;
        srch_o = 0;
        m_drop = 0;
        drop_cyc = -1;
    endfunction

    // Decide the fate of a descriptor strobed in cycle c
    function automatic void model_accept(int c, logic [47:0] tag, logic [8:0] bid);
        exp_t e;
        int   k;
        if (c > srch_t && c < srch_o) begin
            if (m_drop < 65535) m_drop++;
            drop_cyc = c;
            return;
        end
        e.ptype = tag[47:45];
        e.bufid = bid;
        if (tag[47:45] == 3'd6) begin
            e.cyc  = c + 1;
            e.dmac = tag;
            e.hit  = 1'b0;
        end else begin
            e.dmac = tag;
            e.hit  = 1'b0;
            for (k = 0; k < DEPTH; k++) begin
                if (!mem[k][62]) break;
                if (mem[k][61:48] == tag[44:31]) begin
                    e.dmac = mem[k][47:0];
                    e.hit  = 1'b1;
                    break;
                end
            end
            if (k == DEPTH) k = DEPTH - 1;
            srch_t = c;
            srch_o = c + 4 + k;
            e.cyc  = srch_o;
        end
        q.push_back(e);
    endfunction

    always @(negedge clk) begin
        logic ew;
        logic busy;
        int   a;
        ew   = q.size() > 0 && q[0].cyc == cyc;
        busy = cyc > srch_t && cyc < srch_o;
        chk("wr", 64'(bus.o_descriptor_wr), 64'(ew));
        if (ew) begin
            chk("dmac", 64'(bus.ov_dmac), 64'(q[0].dmac));
            chk("type", 64'(bus.ov_pkt_type), 64'(q[0].ptype));
            chk("bufid", 64'(bus.ov_bufid), 64'(q[0].bufid));
            chk("hit", 64'(bus.o_remap_hit), 64'(q[0].hit));
            void'(q.pop_front());
        end else begin
            chk("idle_out", {bus.ov_dmac, 4'(bus.ov_pkt_type), 9'(bus.ov_bufid),
                bus.o_remap_hit, 2'b0}, 64'd0);
        end
        if (bus.o_descriptor_wr) begin
            nwr++;
            last_wr_cyc = cyc;
            last_dmac   = bus.ov_dmac;
            last_bufid  = bus.ov_bufid;
            last_hit    = bus.o_remap_hit;
        end
        chk("idle", 64'(bus.o_lookup_idle), 64'(!busy));
        a = cyc - srch_t - 1;
        if (busy && a < DEPTH) begin
            chk("rd", 64'(bus.o_remap_ram_rd), 64'd1);
            chk("raddr", 64'(bus.ov_remap_ram_raddr), 64'(a));
        end else begin
            chk("rd", 64'(bus.o_remap_ram_rd), 64'd0);
            chk("raddr", 64'(bus.ov_remap_ram_raddr), busy ? 64'(DEPTH - 1) : 64'd0);
        end
        chk("drop", 64'(bus.ov_drop_cnt), 64'(m_drop - (drop_cyc == cyc ? 1 : 0)));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [47:0] tag, input logic [8:0] bid);
        bus.i_descriptor_wr = 1'b1;
        bus.iv_tsntag = tag;
        bus.iv_bufid = bid;
        t_strobe = cyc;
        model_accept(cyc, tag, bid);
        tick(1);
        bus.i_descriptor_wr = 1'b0;
        bus.iv_tsntag = '0;
        bus.iv_bufid = '0;
    endtask

    task automatic clear_table();
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    endtask

    task automatic hit_table();
        clear_table();
        mem[0] = {1'b1, 14'd1, 48'hAAAA_0000_0001};
        mem[1] = {1'b1, 14'd2, 48'hAAAA_0000_0002};
        mem[2] = {1'b1, 14'd3, 48'hAAAA_0000_0003};
        mem[3] = {1'b1, 14'd100, 48'h0011_2233_4455};
    endtask

    initial begin
        int t0;
        int n0;
        bus.i_descriptor_wr = 1'b0;
        bus.iv_tsntag = '0;
        bus.iv_bufid = '0;
        clear_table();
        tick(3);
        chk("rst_idle", 64'(bus.o_lookup_idle), 64'd1);
        rst_n = 1'b1;
        tick(2);

        strobe(48'hC000_0000_1234, 9'd5);
        t0 = t_strobe;
        tick(3);
        chk("be_lat", 64'(last_wr_cyc - t0), 64'd1);
        chk("be_dmac", 64'(last_dmac), 64'hC000_0000_1234);
        chk("be_bufid", 64'(last_bufid), 64'd5);

        hit_table();
        strobe({3'd3, 14'd100, 31'h1234}, 9'd17);
        t0 = t_strobe;
        tick(10);
        chk("hit_lat", 64'(last_wr_cyc - t0), 64'd7);
        chk("hit_dmac", 64'(last_dmac), 64'h0011_2233_4455);
        chk("hit_flag", 64'(last_hit), 64'd1);

        clear_table();
        strobe({3'd1, 14'd7, 31'h55}, 9'd9);
        t0 = t_strobe;
        tick(6);
        chk("inv_lat", 64'(last_wr_cyc - t0), 64'd4);
        chk("inv_dmac", 64'(last_dmac), 64'(48'({3'd1, 14'd7, 31'h55})));
        chk("inv_hit", 64'(last_hit), 64'd0);

        for (int i = 0; i < DEPTH; i++)
            mem[i] = {1'b1, 14'(i), 48'(i + 100)};
        strobe({3'd2, 14'd500, 31'h7}, 9'd3);
        t0 = t_strobe;
        tick(40);
        chk("miss_lat", 64'(last_wr_cyc - t0), 64'd35);
        chk("miss_hit", 64'(last_hit), 64'd0);

        mem[2] = {1'b1, 14'd9, 48'h0000_0000_0B0B};
        mem[5] = {1'b1, 14'd9, 48'h0000_0000_0C0C};
        strobe({3'd4, 14'd9, 31'h0}, 9'd1);
        t0 = t_strobe;
        tick(10);
        chk("dup_lat", 64'(last_wr_cyc - t0), 64'd6);
        chk("dup_dmac", 64'(last_dmac), 64'h0000_0000_0B0B);

        hit_table();
        n0 = nwr;
        strobe({3'd3, 14'd100, 31'h1}, 9'd20);
        t0 = t_strobe;
        tick(1);
        strobe({3'd3, 14'd100, 31'h2}, 9'd30);
        tick(4);
        chk("term_cyc", 64'(cyc - t0), 64'd7);
        strobe(48'hC000_0000_0042, 9'd44);
        tick(3);
        chk("drop_cnt", 64'(bus.ov_drop_cnt), 64'd1);
        chk("drop_nwr", 64'(nwr - n0), 64'd2);
        chk("term_be", 64'(last_wr_cyc - t0), 64'd8);
        chk("term_bufid", 64'(last_bufid), 64'd44);

        for (int i = 0; i < DEPTH; i++)
            mem[i] = {1'b1, 14'(i), 48'(i + 100)};
        strobe({3'd2, 14'd600, 31'h9}, 9'd6);
        tick(4);
        rst_n = 1'b0;
        model_reset();
        n0 = nwr;
        #2;
        chk("rst_mid_idle", 64'(bus.o_lookup_idle), 64'd1);
        chk("rst_mid_drop", 64'(bus.ov_drop_cnt), 64'd0);
        tick(2);
        rst_n = 1'b1;
        tick(40);
        chk("rst_nowr", 64'(nwr - n0), 64'd0);
        strobe(48'hC000_0000_0777, 9'd77);
        t0 = t_strobe;
        tick(3);
        chk("rst_be_lat", 64'(last_wr_cyc - t0), 64'd1);
        chk("rst_be_dmac", 64'(last_dmac), 64'hC000_0000_0777);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
